// File: rtl/instruction_fetch_controller.sv
// ============================================================================
//  Module      : instruction_fetch_controller
//  Description : Owns the LEGv8 program counter, reads the combinational
//                instruction memory after MEM_WAIT extra cycles and hands each
//                word plus its address to decode over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_controller #(
    parameter int ADDR_WIDTH = 12,
    parameter int INST_WIDTH = 32,
    parameter int RESET_PC   = 0,
    parameter int MEM_WAIT   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  branchTaken,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    output logic [ADDR_WIDTH-1:0] pcAddr,
    input  logic [INST_WIDTH-1:0] Inst,
    output logic [INST_WIDTH-1:0] instOut,
    output logic [ADDR_WIDTH-1:0] pcOut,
    output logic                  instValid,
    input  logic                  instReady,
    output logic                  busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    localparam logic [2:0]            c_MEM_WAIT = 3'(MEM_WAIT);
    localparam logic [ADDR_WIDTH-1:0] c_RESET_PC = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP  = ADDR_WIDTH'(4);

    logic [1:0]            r_state;
    logic [2:0]            r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_pc_addr;
    logic [INST_WIDTH-1:0] r_inst_out;
    logic [ADDR_WIDTH-1:0] r_pc_out;
    logic                  r_inst_valid;
    logic                  r_busy;

    logic [1:0]            w_state_nxt;
    logic [2:0]            w_wait_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_addr_nxt;
    logic [INST_WIDTH-1:0] w_inst_out_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_out_nxt;
    logic                  w_inst_valid_nxt;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_unused_tgt_lsbs;

    // Branch targets are word addresses; the byte-offset bits are dropped.
    assign w_target          = {branchTarget[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_tgt_lsbs = ^branchTarget[1:0];

    always_comb begin
        w_state_nxt      = r_state;
        w_wait_nxt       = r_wait_cnt;
        w_pc_addr_nxt    = r_pc_addr;
        w_inst_out_nxt   = r_inst_out;
        w_pc_out_nxt     = r_pc_out;
        w_inst_valid_nxt = r_inst_valid;

        case (r_state)
            c_ST_IDLE: begin
                if (branchTaken) begin
                    w_pc_addr_nxt = w_target;
                end
                if (start) begin
                    w_state_nxt = c_ST_FETCH;
                    w_wait_nxt  = 3'd0;
                end
            end
            c_ST_FETCH, c_ST_HOLD: begin
                if (halt) begin
                    w_state_nxt      = c_ST_IDLE;
                    w_inst_valid_nxt = 1'b0;
                end else if (branchTaken) begin
                    // Redirect wins over a same-cycle accept or capture.
                    w_state_nxt      = c_ST_FETCH;
                    w_pc_addr_nxt    = w_target;
                    w_inst_valid_nxt = 1'b0;
                    w_wait_nxt       = 3'd0;
                end else if (r_state == c_ST_HOLD) begin
                    if (instReady) begin
                        w_state_nxt      = c_ST_FETCH;
                        w_inst_valid_nxt = 1'b0;
                        w_wait_nxt       = 3'd0;
                    end
                end else if (r_wait_cnt != c_MEM_WAIT) begin
                    w_wait_nxt = r_wait_cnt + 3'd1;
                end else begin
                    w_state_nxt      = c_ST_HOLD;
                    w_inst_out_nxt   = Inst;
                    w_pc_out_nxt     = r_pc_addr;
                    w_inst_valid_nxt = 1'b1;
                    w_pc_addr_nxt    = r_pc_addr + c_PC_STEP;
                end
            end
            default: begin
                w_state_nxt      = c_ST_IDLE;
                w_inst_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_wait_cnt   <= 3'd0;
            r_pc_addr    <= c_RESET_PC;
            r_inst_out   <= '0;
            r_pc_out     <= '0;
            r_inst_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_pc_addr    <= w_pc_addr_nxt;
            r_inst_out   <= w_inst_out_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_busy       <= (w_state_nxt != c_ST_IDLE);
        end
    end

    assign pcAddr    = r_pc_addr;
    assign instOut   = r_inst_out;
    assign pcOut     = r_pc_out;
    assign instValid = r_inst_valid;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_controller.sv
// ============================================================================
//  Module      : tb_instruction_fetch_controller
//  Description : Two fetch controllers (MEM_WAIT 0 and 3) on shared stimulus,
//                each compared every cycle against a countdown-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt;
    logic        branchTaken;
    logic [11:0] branchTarget;
    logic        instReady;

    logic [11:0] p0_addr, p0_pcout, p3_addr, p3_pcout;
    logic [31:0] p0_inst, p0_iout, p3_inst, p3_iout;
    logic        p0_valid, p0_busy, p3_valid, p3_busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Instruction memory: word[i] = 0x1000_0000 + i.
    assign p0_inst = 32'h1000_0000 + {22'd0, p0_addr[11:2]};
    assign p3_inst = 32'h1000_0000 + {22'd0, p3_addr[11:2]};

    instruction_fetch_controller #(.ADDR_WIDTH(12), .INST_WIDTH(32), .RESET_PC(0), .MEM_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .pcAddr(p0_addr), .Inst(p0_inst), .instOut(p0_iout), .pcOut(p0_pcout),
        .instValid(p0_valid), .instReady(instReady), .busy(p0_busy)
    );

    instruction_fetch_controller #(.ADDR_WIDTH(12), .INST_WIDTH(32), .RESET_PC(0), .MEM_WAIT(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .pcAddr(p3_addr), .Inst(p3_inst), .instOut(p3_iout), .pcOut(p3_pcout),
        .instValid(p3_valid), .instReady(instReady), .busy(p3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: 'left' counts idle cycles still to pass before the next capture.
    typedef struct {
        bit          active;
        bit          valid;
        int          left;
        logic [11:0] pc;
        logic [11:0] ipc;
        logic [31:0] inst;
    } mdl_t;

    mdl_t m0, m3;

    function automatic mdl_t step(mdl_t m, int mw, bit rst, bit st, bit hl, bit br,
                                  logic [11:0] tg, bit rd);
        mdl_t n = m;
        logic [11:0] al;
        al = tg & 12'hFFC;
        if (rst) begin
            n.active = 0; n.valid = 0; n.left = 0;
            n.pc = 12'd0; n.ipc = 12'd0; n.inst = 32'd0;
        end else if (!m.active) begin
            if (br) n.pc = al;
            if (st) begin n.active = 1; n.left = mw; end
        end else if (hl) begin
            n.active = 0; n.valid = 0;
        end else if (br) begin
            n.pc = al; n.valid = 0; n.left = mw;
        end else if (m.valid) begin
            if (rd) begin n.valid = 0; n.left = mw; end
        end else if (m.left > 0) begin
            n.left = m.left - 1;
        end else begin
            n.inst  = 32'h1000_0000 + 32'(m.pc >> 2);
            n.ipc   = m.pc;
            n.valid = 1;
            n.pc    = m.pc + 12'd4;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 <= step(m0, 0, reset, start, halt, branchTaken, branchTarget, instReady);
        m3 <= step(m3, 3, reset, start, halt, branchTaken, branchTarget, instReady);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("d0.pcAddr",    32'(p0_addr),   32'(m0.pc));
            check("d0.instValid", 32'(p0_valid),  32'(m0.valid));
            check("d0.instOut",   p0_iout,        m0.inst);
            check("d0.pcOut",     32'(p0_pcout),  32'(m0.ipc));
            check("d0.busy",      32'(p0_busy),   32'(m0.active));
            check("d3.pcAddr",    32'(p3_addr),   32'(m3.pc));
            check("d3.instValid", 32'(p3_valid),  32'(m3.valid));
            check("d3.instOut",   p3_iout,        m3.inst);
            check("d3.pcOut",     32'(p3_pcout),  32'(m3.ipc));
            check("d3.busy",      32'(p3_busy),   32'(m3.active));
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for the next rising instValid on dut0, then check the word literally.
    task automatic wait_rise0(input string nm, input logic [11:0] epc, input logic [31:0] einst);
        int b;
        b = 0;
        while (p0_valid && b < 40) begin @(negedge clk); b++; end
        while (!p0_valid && b < 40) begin @(negedge clk); b++; end
        if (b >= 40) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout waiting for instValid", nm);
        end else begin
            check({nm, ".pcOut"},   32'(p0_pcout), 32'(epc));
            check({nm, ".instOut"}, p0_iout,       einst);
        end
    endtask

    int k0[$];
    int k3[$];

    initial begin
        reset = 1'b1; start = 1'b0; halt = 1'b0; branchTaken = 1'b0;
        branchTarget = 12'd0; instReady = 1'b0;
        @(negedge clk);
        do_reset(2);
        chk_en = 1;

        // Reset values
        check("rst.pcAddr",    32'(p0_addr),  32'd0);
        check("rst.instValid", 32'(p0_valid), 32'd0);
        check("rst.busy",      32'(p0_busy),  32'd0);
        check("rst.instOut",   p0_iout,       32'd0);
        check("rst.pcOut",     32'(p0_pcout), 32'd0);

        // Streaming with ready high; dut3 timing observed alongside
        instReady = 1'b1;
        pulse_start();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            if (p0_valid) begin
                if (k0.size() < 4) begin
                    check("seq.pcOut",   32'(p0_pcout), 32'(k0.size() * 4));
                    check("seq.instOut", p0_iout,       32'h1000_0000 + 32'(k0.size()));
                end
                k0.push_back(k);
            end
            if (p3_valid) k3.push_back(k);
        end
        check("seq.first_valid_edge", 32'(k0.size() > 0 ? k0[0] : -1), 32'd1);
        check("seq.spacing", 32'(k0.size() >= 4 ? k0[3] - k0[0] : -1), 32'd6);
        check("wait.first_valid_edge", 32'(k3.size() > 0 ? k3[0] : -1), 32'd4);
        check("wait.accept_to_next",   32'(k3.size() > 1 ? k3[1] - k3[0] : -1), 32'd5);

        // Backpressure on the first instruction
        do_reset(2);
        instReady = 1'b0;
        pulse_start();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp.instValid", 32'(p0_valid), 32'd1);
            check("bp.instOut",   p0_iout,       32'h1000_0000);
            check("bp.pcOut",     32'(p0_pcout), 32'd0);
            check("bp.pcAddr",    32'(p0_addr),  32'd4);
            @(negedge clk);
        end
        instReady = 1'b1;
        wait_rise0("bp.next", 12'd4, 32'h1000_0001);

        // Branch in HOLD beats a simultaneous accept
        branchTaken = 1'b1; branchTarget = 12'h02B;
        @(negedge clk);
        branchTaken = 1'b0;
        check("br.pcAddr",    32'(p0_addr),  32'h028);
        check("br.instValid", 32'(p0_valid), 32'd0);
        wait_rise0("br.target", 12'h028, 32'h1000_000A);

        // Halt in HOLD, then resume after the discarded word
        do_reset(2);
        pulse_start();
        wait_rise0("hr.w0", 12'd0, 32'h1000_0000);
        wait_rise0("hr.w1", 12'd4, 32'h1000_0001);
        wait_rise0("hr.w2", 12'd8, 32'h1000_0002);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("halt.instValid", 32'(p0_valid), 32'd0);
        check("halt.busy",      32'(p0_busy),  32'd0);
        check("halt.pcAddr",    32'(p0_addr),  32'd12);
        pulse_start();
        wait_rise0("resume", 12'd12, 32'h1000_0003);

        // Wrap-around past the top of the address space
        branchTaken = 1'b1; branchTarget = 12'hFFE;
        @(negedge clk);
        branchTaken = 1'b0;
        check("wrap.pcAddr", 32'(p0_addr), 32'hFFC);
        wait_rise0("wrap.top",  12'hFFC, 32'h1000_03FF);
        wait_rise0("wrap.zero", 12'h000, 32'h1000_0000);

        // Reset in the middle of a wait period
        do_reset(2);
        branchTaken = 1'b1; branchTarget = 12'h100;
        @(negedge clk);
        branchTaken = 1'b0;
        pulse_start();
        @(negedge clk);
        check("midwait.busy_before", 32'(p3_busy), 32'd1);
        check("midwait.pc_before",   32'(p3_addr), 32'h100);
        do_reset(1);
        check("midwait.busy",   32'(p3_busy),  32'd0);
        check("midwait.pcAddr", 32'(p3_addr),  32'd0);
        check("midwait.valid",  32'(p3_valid), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 499) == 0);
            start        = ($urandom_range(0, 5) == 0);
            halt         = ($urandom_range(0, 39) == 0);
            branchTaken  = ($urandom_range(0, 19) == 0);
            branchTarget = 12'($urandom_range(0, 4095));
            instReady    = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        reset = 1'b0; start = 1'b0; halt = 1'b0; branchTaken = 1'b0;
        @(negedge clk);
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_controller.md
# instruction_fetch_controller

- Sequences the LEGv8 instruction memory: owns the program counter and drives `pcAddr`.
- Samples `Inst` after a configurable number of wait cycles and presents each fetched word, with its address, to decode through a valid/ready handshake.
- Handles start, halt and branch redirect.
- Sits between the combinational `instructionMemory` block and the decode stage.

## Interface

Parameters:
- `ADDR_WIDTH`, 12, width of the instruction address (byte address, word-aligned).
- `INST_WIDTH`, 32, instruction word width.
- `RESET_PC`, 0, PC loaded on reset. Must be a multiple of 4.
- `MEM_WAIT`, 0, extra cycles to wait after driving `pcAddr` before sampling `Inst`. Range 0..7.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin fetching at the current PC. Honoured only in IDLE.
- `halt` in 1: stop fetching and return to IDLE.
- `branchTaken` in 1: redirect request.
- `branchTarget` in ADDR_WIDTH: redirect address. Bits [1:0] are ignored (forced 0).
- `pcAddr` out ADDR_WIDTH: address driven to instruction memory (registered).
- `Inst` in INST_WIDTH: instruction memory read data.
- `instOut` out INST_WIDTH: captured instruction.
- `pcOut` out ADDR_WIDTH: address of `instOut`.
- `instValid` out 1: `instOut`/`pcOut` valid.
- `instReady` in 1: decode accepts when `instValid && instReady`.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation

States: IDLE, FETCH, HOLD. Internal 3-bit `waitCnt`.

- **Reset:** state IDLE, `pcAddr`=RESET_PC, `instOut`=0, `pcOut`=0, `instValid`=0, `busy`=0, `waitCnt`=0.
- **IDLE:**
  - `start`=1 → FETCH with `waitCnt`=0.
  - `branchTaken` in IDLE loads `pcAddr`=`{branchTarget[ADDR_WIDTH-1:2],2'b00}` and stays in IDLE.
  - `halt` has no effect.
- **FETCH:**
  - If `waitCnt`<MEM_WAIT: increment `waitCnt`.
  - Otherwise capture: `instOut`←`Inst`, `pcOut`←`pcAddr`, `instValid`←1, `pcAddr`←`pcAddr`+4, → HOLD.
- **HOLD:**
  - `instValid` held high, and `instOut`/`pcOut` held stable, until accepted.
  - On accept: `instValid`←0, `waitCnt`←0, → FETCH.
- **Priority each cycle:** `reset` > `halt` > `branchTaken` > accept/capture.
  - **halt** (FETCH or HOLD): → IDLE, `instValid`←0, `pcAddr` unchanged. A held, unaccepted instruction is discarded. `pcAddr` already points past it, so restart resumes after it.
  - **branchTaken** (FETCH or HOLD): `pcAddr`←aligned target, `instValid`←0, `waitCnt`←0, → FETCH.
    - A held instruction is discarded even if `instReady`=1 that cycle. A simultaneous accept is treated as not having occurred.
    - An in-progress capture is cancelled.
- **Arithmetic:** PC increment is modulo 2^ADDR_WIDTH. 0xFFC + 4 = 0x000, with no flag.
- `start` outside IDLE is ignored.

## Timing

- `start` sampled at edge E0 → FETCH during cycle E0..E1.
  - MEM_WAIT=0: capture at E1; `instValid`=1 and `pcAddr`=old+4 visible after E1.
  - General: first `instValid` appears MEM_WAIT+1 edges after the `start` edge.
- Accept at edge A → `instValid` low after A. Next capture at A+MEM_WAIT+1.
  - Sustained throughput with `instReady` tied 1: one instruction per MEM_WAIT+2 cycles.
- Branch at edge B → `pcAddr`=target after B. First target instruction valid after B+MEM_WAIT+1.
- `Inst` is sampled in the same cycle `pcAddr` is stable. Memory must be combinational or settle within MEM_WAIT+1 cycles.
- All outputs are registered; no combinational input-to-output paths.

## Test plan

- **Reset values:** memory word[i]=0x1000_0000+i, MEM_WAIT=0. Assert reset 2 cycles → all outputs at reset values. Pulse start → sequence (`pcOut`,`instOut`) = (0,0x10000000), (4,0x10000001), (8,0x10000002), (12,0x10000003), each `instValid` one cycle apart by 2 cycles.
- **Backpressure:** hold `instReady`=0 for 5 cycles on the first instruction → `instValid`, `instOut`=0x10000000 and `pcOut`=0 stable throughout, `pcAddr`=4. Raise ready → next word 0x10000001 at `pcOut`=4.
- **Branch vs. accept:** `branchTaken`=1 with `branchTarget`=0x02B in HOLD while `instReady`=1 → held word dropped, `pcAddr`=0x028, next valid pair (0x028, 0x1000000A).
- **Halt and resume:** `halt` in HOLD at `pcOut`=8 → IDLE, `instValid`=0, `busy`=0, `pcAddr`=12. `start` → next valid `pcOut`=12.
- **Wrap-around:** branch to 0xFFC → outputs (0xFFC, word[1023]) then (0x000, word[0]).
- **Wait states:** MEM_WAIT=3 → `instValid` exactly 4 edges after the start edge. Accept-to-next-valid 4 edges. Reset asserted mid-wait → state IDLE, `pcAddr`=RESET_PC next cycle.
